instr_fetch_sequencer: RTL

Drives the fetch/execute phase strobes and the held instruction word consumed by the instruction decoder, and acts as the bus initiator for instruction reads. Each instruction is read from the instruction memory, latched, and presented unchanged for two execute phases. The block also detects the halt condition and counts retired instructions. It sits between the program counter and the memory bus on one side and the decoder and register file on the other.

---
 rtl/instr_fetch_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_fetch_sequencer.sv
// Fetch/execute sequencer: one bus read per instruction, word held for EXEC1/EXEC2; >=3 cycles/instr.
// Stalls in FETCH on waitrequest and in EXEC2 on exec2_stall; FETCH_BYTE_SWAP_EN byte-reverses the fetched word.
module instr_fetch_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic        halt_req,
    input  logic        exec2_stall,
    output logic [31:0] address,
    output logic        read,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] current_instruction,
    output logic        fetch,
    output logic        exec_one,
    output logic        exec_two,
    output logic        active,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC1  = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_address;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic [31:0] w_fetch_word;
    logic        w_accept;
    logic        w_retire;
    logic        w_enter_fetch;
    logic        w_pc_unused;

    assign w_pc_unused   = ^pc[1:0];
    assign w_accept      = (r_state == S_FETCH) && !waitrequest;
    assign w_retire      = (r_state == S_EXEC2) && !exec2_stall;
    assign w_enter_fetch = (w_next == S_FETCH) && (r_state != S_FETCH);

`ifdef FETCH_BYTE_SWAP_EN
    assign w_fetch_word = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]};
`else
    assign w_fetch_word = readdata;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = waitrequest ? S_FETCH : S_EXEC1;
            S_EXEC1:  w_next = S_EXEC2;
            S_EXEC2: begin
                if (!exec2_stall) begin
                    w_next = halt_req ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        fetch      = 1'b0;
        exec_one   = 1'b0;
        exec_two   = 1'b0;
        read       = 1'b0;
        byteenable = 4'h0;
        active     = 1'b1;
        case (r_state)
            S_FETCH: begin
                fetch      = 1'b1;
                read       = 1'b1;
                byteenable = 4'hF;
            end
            S_EXEC1:  exec_one = 1'b1;
            S_EXEC2:  exec_two = 1'b1;
            S_HALTED: active   = 1'b0;
            default: ;
        endcase
    end

    // Address is captured once on FETCH entry so pc may move while the bus waits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_address <= 32'h0;
            r_instr   <= 32'h0;
            r_count   <= 32'h0;
        end else begin
            if (w_enter_fetch) begin
                r_address <= {pc[31:2], 2'b00};
            end
            if (w_accept) begin
                r_instr <= w_fetch_word;
            end
            if (w_retire) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign address             = r_address;
    assign current_instruction = r_instr;
    assign instr_count         = r_count;

endmodule
